// File: rtl/ibex_rvfi_ext_pkg.sv
// Shared types for the RVFI ext-signal capture buffer.
// Optional RVFI_EXT_DELTA_EN adds an mcycle delta field to each record.
package ibex_rvfi_ext_pkg;

  localparam int unsigned EXT_MHPM_NUM = 10;
  localparam int unsigned DELTA_W      = 32;

  typedef enum logic [1:0] {
    CAP_OFF   = 2'b00,
    CAP_ALL   = 2'b01,
    CAP_IRQ   = 2'b10,
    CAP_DECIM = 2'b11
  } cap_mode_e;

  typedef struct packed {
`ifdef RVFI_EXT_DELTA_EN
    logic [DELTA_W-1:0]               mcycle_delta;
`endif
    logic                             lost;
    logic [63:0]                      order;
    logic [31:0]                      mip;
    logic                             nmi;
    logic                             nmi_int;
    logic                             debug_req;
    logic                             debug_mode;
    logic                             rf_wr_suppress;
    logic                             ic_scr_key_valid;
    logic                             irq_valid;
    logic [63:0]                      mcycle;
    logic [EXT_MHPM_NUM-1:0][31:0]    mhpmcounters;
    logic [EXT_MHPM_NUM-1:0][31:0]    mhpmcountersh;
  } ext_rec_t;

  // Unsigned mcycle difference clamped to the delta field width.
  function automatic logic [DELTA_W-1:0] sat_delta(input logic [63:0] cur,
                                                   input logic [63:0] prev);
    logic [63:0] diff;
    diff = cur - prev;
    return (diff[63:DELTA_W] != '0) ? '1 : diff[DELTA_W-1:0];
  endfunction

endpackage

// File: rtl/ibex_rvfi_ext_fifo.sv
// Generic synchronous FIFO; head is read combinationally, writes land at the tail.
module ibex_rvfi_ext_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  T                         wdata_i,
  output T                         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  T                mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_q <= level_q + 1'b1;
      else if (pop_ok && !push_ok) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/ibex_rvfi_ext_capture.sv
// Captures RVFI ext side-channel signals on qualifying retirements into a FIFO.
// Build with RVFI_EXT_DELTA_EN to add a saturating mcycle delta to each record.
module ibex_rvfi_ext_capture
  import ibex_rvfi_ext_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned MHPM_NUM     = EXT_MHPM_NUM,
  parameter int unsigned SAMPLE_DIV_W = 8,
  parameter int unsigned DROP_CNT_W   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [1:0]                    mode_i,
  input  logic [SAMPLE_DIV_W-1:0]       sample_div_i,
  input  logic                          rvfi_valid_i,
  input  logic [63:0]                   rvfi_order_i,
  input  logic [31:0]                   rvfi_ext_mip_i,
  input  logic                          rvfi_ext_nmi_i,
  input  logic                          rvfi_ext_nmi_int_i,
  input  logic                          rvfi_ext_debug_req_i,
  input  logic                          rvfi_ext_debug_mode_i,
  input  logic                          rvfi_ext_rf_wr_suppress_i,
  input  logic                          rvfi_ext_ic_scr_key_valid_i,
  input  logic                          rvfi_ext_irq_valid_i,
  input  logic [63:0]                   rvfi_ext_mcycle_i,
  input  logic [MHPM_NUM-1:0][31:0]     rvfi_ext_mhpmcounters_i,
  input  logic [MHPM_NUM-1:0][31:0]     rvfi_ext_mhpmcountersh_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output ext_rec_t                      out_rec_o,
  output logic [DROP_CNT_W-1:0]         drop_cnt_o,
  output logic [$clog2(DEPTH):0]        level_o
);

  cap_mode_e                mode;
  logic [SAMPLE_DIV_W-1:0]  dec_cnt_q, div_m1;
  logic                     cap, push, pop, drop, full, empty, lost_q;
  ext_rec_t                 rec_in, rec_head;

  assign mode   = cap_mode_e'(mode_i);
  assign div_m1 = (sample_div_i == '0) ? '0 : sample_div_i - 1'b1;

  always_comb begin
    cap = 1'b0;
    unique case (mode)
      CAP_OFF:   cap = 1'b0;
      CAP_ALL:   cap = rvfi_valid_i;
      CAP_IRQ:   cap = rvfi_valid_i &&
                       (rvfi_ext_irq_valid_i | rvfi_ext_nmi_i | rvfi_ext_nmi_int_i);
      CAP_DECIM: cap = rvfi_valid_i && (dec_cnt_q == '0);
      default:   cap = 1'b0;
    endcase
  end

  // >= rather than == keeps the counter bounded if the divisor shrinks mid-run.
  always_ff @(posedge clk_i) begin
    if (rst_i || mode != CAP_DECIM) dec_cnt_q <= '0;
    else if (rvfi_valid_i)          dec_cnt_q <= (dec_cnt_q >= div_m1) ? '0 : dec_cnt_q + 1'b1;
  end

  assign out_valid_o = !empty;
  assign pop         = out_valid_o && out_ready_i;
  assign push        = cap && (!full || pop);
  assign drop        = cap && full && !pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
      lost_q     <= 1'b0;
    end else begin
      if (drop && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      if (drop)      lost_q <= 1'b1;
      else if (push) lost_q <= 1'b0;
    end
  end

`ifdef RVFI_EXT_DELTA_EN
  logic [63:0] prev_mcycle_q;
  logic        have_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_mcycle_q <= '0;
      have_prev_q   <= 1'b0;
    end else if (push) begin
      prev_mcycle_q <= rvfi_ext_mcycle_i;
      have_prev_q   <= 1'b1;
    end
  end
`endif

  always_comb begin
    rec_in                  = '0;
`ifdef RVFI_EXT_DELTA_EN
    rec_in.mcycle_delta     = have_prev_q ? sat_delta(rvfi_ext_mcycle_i, prev_mcycle_q) : '0;
`endif
    rec_in.lost             = lost_q;
    rec_in.order            = rvfi_order_i;
    rec_in.mip              = rvfi_ext_mip_i;
    rec_in.nmi              = rvfi_ext_nmi_i;
    rec_in.nmi_int          = rvfi_ext_nmi_int_i;
    rec_in.debug_req        = rvfi_ext_debug_req_i;
    rec_in.debug_mode       = rvfi_ext_debug_mode_i;
    rec_in.rf_wr_suppress   = rvfi_ext_rf_wr_suppress_i;
    rec_in.ic_scr_key_valid = rvfi_ext_ic_scr_key_valid_i;
    rec_in.irq_valid        = rvfi_ext_irq_valid_i;
    rec_in.mcycle           = rvfi_ext_mcycle_i;
    rec_in.mhpmcounters     = rvfi_ext_mhpmcounters_i;
    rec_in.mhpmcountersh    = rvfi_ext_mhpmcountersh_i;
  end

  ibex_rvfi_ext_fifo #(
    .DEPTH (DEPTH),
    .T     (ext_rec_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (rec_in),
    .rdata_o (rec_head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

  assign out_rec_o = empty ? '0 : rec_head;

endmodule

// File: tb/tb_ibex_rvfi_ext_capture.sv
// Self-checking bench: stimulus table plus hand sequences, scoreboard of expected records.
module tb_ibex_rvfi_ext_capture;
  import ibex_rvfi_ext_pkg::*;

  localparam int DEPTH = 8;
  localparam int MHPM  = 10;
  localparam int SDW   = 8;
  localparam int DCW   = 16;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [1:0]              mode_i;
  logic [SDW-1:0]          sample_div_i;
  logic                    rvfi_valid_i;
  logic [63:0]             rvfi_order_i;
  logic [31:0]             rvfi_ext_mip_i;
  logic                    rvfi_ext_nmi_i, rvfi_ext_nmi_int_i, rvfi_ext_debug_req_i;
  logic                    rvfi_ext_debug_mode_i, rvfi_ext_rf_wr_suppress_i;
  logic                    rvfi_ext_ic_scr_key_valid_i, rvfi_ext_irq_valid_i;
  logic [63:0]             rvfi_ext_mcycle_i;
  logic [MHPM-1:0][31:0]   rvfi_ext_mhpmcounters_i, rvfi_ext_mhpmcountersh_i;
  logic                    out_valid_o, out_ready_i;
  ext_rec_t                out_rec_o;
  logic [DCW-1:0]          drop_cnt_o;
  logic [$clog2(DEPTH):0]  level_o;

  ibex_rvfi_ext_capture #(
    .DEPTH(DEPTH), .MHPM_NUM(MHPM), .SAMPLE_DIV_W(SDW), .DROP_CNT_W(DCW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .sample_div_i(sample_div_i),
    .rvfi_valid_i(rvfi_valid_i), .rvfi_order_i(rvfi_order_i),
    .rvfi_ext_mip_i(rvfi_ext_mip_i), .rvfi_ext_nmi_i(rvfi_ext_nmi_i),
    .rvfi_ext_nmi_int_i(rvfi_ext_nmi_int_i), .rvfi_ext_debug_req_i(rvfi_ext_debug_req_i),
    .rvfi_ext_debug_mode_i(rvfi_ext_debug_mode_i),
    .rvfi_ext_rf_wr_suppress_i(rvfi_ext_rf_wr_suppress_i),
    .rvfi_ext_ic_scr_key_valid_i(rvfi_ext_ic_scr_key_valid_i),
    .rvfi_ext_irq_valid_i(rvfi_ext_irq_valid_i), .rvfi_ext_mcycle_i(rvfi_ext_mcycle_i),
    .rvfi_ext_mhpmcounters_i(rvfi_ext_mhpmcounters_i),
    .rvfi_ext_mhpmcountersh_i(rvfi_ext_mhpmcountersh_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_rec_o(out_rec_o),
    .drop_cnt_o(drop_cnt_o), .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  div;
    logic        valid, irq, nmi, ready;
    logic [63:0] order, mcycle;
    logic        cap;
  } vec_t;

  vec_t        tbl[$];
  ext_rec_t    exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] m_drop;
  logic        m_lost, m_have_prev;
  logic [63:0] m_prev;

  function automatic vec_t mk(logic [1:0] mode, logic [7:0] div, logic valid, logic irq,
                              logic nmi, logic ready, logic [63:0] order,
                              logic [63:0] mcycle, logic cap);
    vec_t v;
    v.mode = mode; v.div = div; v.valid = valid; v.irq = irq; v.nmi = nmi;
    v.ready = ready; v.order = order; v.mcycle = mcycle; v.cap = cap;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_rec(input string name, input ext_rec_t act, input ext_rec_t req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got order=%0h lost=%0b mcycle=%0h, expected order=%0h lost=%0b mcycle=%0h",
               name, act.order, act.lost, act.mcycle, req.order, req.lost, req.mcycle);
    end
  endtask

  task automatic set_in(input logic [1:0] mode, input logic [7:0] div, input logic valid,
                        input logic irq, input logic nmi, input logic ready,
                        input logic [63:0] order, input logic [63:0] mcycle);
    mode_i = mode; sample_div_i = div; rvfi_valid_i = valid;
    rvfi_ext_irq_valid_i = irq; rvfi_ext_nmi_i = nmi; rvfi_ext_nmi_int_i = 1'b0;
    out_ready_i = ready; rvfi_order_i = order; rvfi_ext_mcycle_i = mcycle;
    rvfi_ext_mip_i = order[31:0] ^ 32'hA5A5_0000;
    rvfi_ext_debug_req_i = order[0];
    rvfi_ext_debug_mode_i = order[1];
    rvfi_ext_rf_wr_suppress_i = order[2];
    rvfi_ext_ic_scr_key_valid_i = order[3];
    for (int i = 0; i < MHPM; i++) begin
      rvfi_ext_mhpmcounters_i[i]  = {order[15:0], 16'(i)};
      rvfi_ext_mhpmcountersh_i[i] = ~{order[15:0], 16'(i)};
    end
  endtask

  function automatic ext_rec_t cur_rec();
    ext_rec_t r;
    r = '0;
    r.order = rvfi_order_i; r.mip = rvfi_ext_mip_i; r.nmi = rvfi_ext_nmi_i;
    r.nmi_int = rvfi_ext_nmi_int_i; r.debug_req = rvfi_ext_debug_req_i;
    r.debug_mode = rvfi_ext_debug_mode_i; r.rf_wr_suppress = rvfi_ext_rf_wr_suppress_i;
    r.ic_scr_key_valid = rvfi_ext_ic_scr_key_valid_i; r.irq_valid = rvfi_ext_irq_valid_i;
    r.mcycle = rvfi_ext_mcycle_i;
    r.mhpmcounters = rvfi_ext_mhpmcounters_i; r.mhpmcountersh = rvfi_ext_mhpmcountersh_i;
    return r;
  endfunction

  // One clock: check head, update scoreboard for this cycle's pop/capture, check counters.
  task automatic cycle(input logic exp_cap);
    ext_rec_t r;
    logic [63:0] d;
    check("out_valid", out_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) check_rec("head_rec", out_rec_o, exp_q[0]);
    else                   check_rec("idle_rec", out_rec_o, '0);
    if (exp_q.size() != 0 && out_ready_i) void'(exp_q.pop_front());
    if (exp_cap) begin
      if (exp_q.size() == DEPTH) begin
        if (m_drop != 16'hFFFF) m_drop++;
        m_lost = 1'b1;
      end else begin
        r = cur_rec();
        r.lost = m_lost;
        d = rvfi_ext_mcycle_i - m_prev;
`ifdef RVFI_EXT_DELTA_EN
        r.mcycle_delta = !m_have_prev ? 32'd0 : (d > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
`endif
        exp_q.push_back(r);
        m_lost = 1'b0;
        m_prev = rvfi_ext_mcycle_i;
        m_have_prev = 1'b1;
      end
    end
    @(posedge clk_i); #1;
    check("level", 64'(level_o), 64'(exp_q.size()));
    check("drop_cnt", drop_cnt_o, m_drop);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_q.delete();
    m_drop = '0; m_lost = 1'b0; m_prev = '0; m_have_prev = 1'b0;
    set_in(2'b00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    check("rst_level", 64'(level_o), 64'd0);
    check("rst_valid", out_valid_o, 1'b0);
    check("rst_drop", drop_cnt_o, 64'd0);
    check_rec("rst_rec", out_rec_o, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(2'b01, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);
      cycle(1'b0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(2'b00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    do_reset();

    // mode 01 three retirements (deltas 0/5/7), mode 00 ignored, then decimation and irq modes
    tbl.push_back(mk(2'b01, 8'd0, 1, 0, 0, 1, 64'd1, 64'd100, 1));
    tbl.push_back(mk(2'b01, 8'd0, 1, 0, 0, 1, 64'd2, 64'd105, 1));
    tbl.push_back(mk(2'b01, 8'd0, 1, 0, 0, 1, 64'd3, 64'd112, 1));
    tbl.push_back(mk(2'b01, 8'd0, 0, 0, 0, 1, 64'd0, 64'd0, 0));
    tbl.push_back(mk(2'b01, 8'd0, 0, 0, 0, 1, 64'd0, 64'd0, 0));
    tbl.push_back(mk(2'b00, 8'd0, 1, 1, 1, 1, 64'd5, 64'd120, 0));
    tbl.push_back(mk(2'b00, 8'd0, 1, 0, 0, 1, 64'd6, 64'd121, 0));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(2'b11, 8'd4, 1, 0, 0, 1, 64'(i), 64'(300 + i), (i % 4) == 0));
    tbl.push_back(mk(2'b10, 8'd0, 1, 0, 0, 1, 64'd40, 64'd400, 0));
    tbl.push_back(mk(2'b10, 8'd0, 1, 1, 0, 1, 64'd41, 64'd401, 1));
    tbl.push_back(mk(2'b10, 8'd0, 1, 0, 0, 1, 64'd42, 64'd402, 0));
    tbl.push_back(mk(2'b10, 8'd0, 1, 0, 0, 1, 64'd43, 64'd403, 0));
    tbl.push_back(mk(2'b10, 8'd0, 1, 0, 1, 1, 64'd44, 64'd404, 1));
    tbl.push_back(mk(2'b10, 8'd0, 0, 0, 0, 1, 64'd0, 64'd0, 0));
    tbl.push_back(mk(2'b10, 8'd0, 0, 0, 0, 1, 64'd0, 64'd0, 0));
    foreach (tbl[k]) begin
      set_in(tbl[k].mode, tbl[k].div, tbl[k].valid, tbl[k].irq, tbl[k].nmi,
             tbl[k].ready, tbl[k].order, tbl[k].mcycle);
      cycle(tbl[k].cap);
    end

    // overflow: 10 retirements into 8 entries, then lost flag on the next accepted record
    for (int i = 0; i < 10; i++) begin
      set_in(2'b01, 8'd0, 1, 0, 0, 0, 64'(10 + i), 64'(200 + i));
      cycle(1'b1);
    end
    check("ovf_level", 64'(level_o), 64'd8);
    check("ovf_drop", drop_cnt_o, 64'd2);
    idle(9);
    set_in(2'b01, 8'd0, 1, 0, 0, 0, 64'd30, 64'd230);
    cycle(1'b1);
    check("lost_set", out_rec_o.lost, 1'b1);
    set_in(2'b01, 8'd0, 1, 0, 0, 1, 64'd31, 64'd240);
    cycle(1'b1);
    check("lost_clr", out_rec_o.lost, 1'b0);
    idle(2);

    // full with capture and pop in the same cycle
    for (int i = 0; i < 8; i++) begin
      set_in(2'b01, 8'd0, 1, 0, 0, 0, 64'(50 + i), 64'(500 + i));
      cycle(1'b1);
    end
    set_in(2'b01, 8'd0, 1, 0, 0, 1, 64'd58, 64'd600);
    cycle(1'b1);
    check("fullpop_level", 64'(level_o), 64'd8);
    check("fullpop_drop", drop_cnt_o, 64'd2);
    idle(9);

    // reset with 5 queued records
    for (int i = 0; i < 5; i++) begin
      set_in(2'b01, 8'd0, 1, 0, 0, 0, 64'(70 + i), 64'(700 + i));
      cycle(1'b1);
    end
    check("pre_rst_level", 64'(level_o), 64'd5);
    set_in(2'b01, 8'd0, 1, 0, 0, 0, 64'd80, 64'd800);
    do_reset();

    // drop counter saturation
    for (int i = 0; i < 8 + 65534; i++) begin
      set_in(2'b01, 8'd0, 1, 0, 0, 0, 64'(1000 + i), 64'(5000 + i));
      cycle(1'b1);
    end
    check("drop_near_sat", drop_cnt_o, 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      set_in(2'b01, 8'd0, 1, 0, 0, 0, 64'(90000 + i), 64'(90000 + i));
      cycle(1'b1);
    end
    check("drop_sat", drop_cnt_o, 64'hFFFF);
    idle(9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
